// File: rtl/gray_to_bin_serial.sv
// -----------------------------------------------------------------------------
// gray_to_bin_serial
//
// Bit-serial Gray-to-binary decoder. A Gray word is accepted on the input
// handshake and resolved MSB-first, one bit per clock, using
//   bin[i] = bin[i+1] ^ gray[i]   (bin[WIDTH-1] = gray[WIDTH-1])
// The finished word is then presented on the output handshake and held until
// the consumer takes it.
//
// Timing (default WIDTH=8): accept edge = edge 0, conversion on edges 1..8,
// out_valid high after edge 8. A transfer edge in DONE returns to IDLE, so the
// throughput is one word per WIDTH+2 cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream presents a Gray word on gray
//   in_ready   block can accept a word this cycle (IDLE only)
//   gray       Gray-coded input word
//   out_valid  bin holds a completed conversion (DONE only)
//   out_ready  downstream accepts bin this cycle
//   bin        decoded binary word
//   busy       high while converting (CONV only)
// -----------------------------------------------------------------------------
module gray_to_bin_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] gray_q;    // word captured at accept; gray is ignored after
  logic [IDX_W-1:0] idx;       // bit currently being resolved, counts down
  logic             prev_bit;  // bin[idx+1]; zero before the MSB is written
  logic             new_bit;
  logic             last_bit;
  logic             accept;

  // The previously resolved bit is carried in prev_bit instead of reading
  // bin[idx+1], which avoids an out-of-range index at the MSB: with
  // prev_bit cleared on accept, the MSB step reduces to bin = gray.
  assign new_bit  = prev_bit ^ gray_q[idx];
  assign last_bit = (idx == '0);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = CONV;
        end
      end

      CONV: begin
        busy = 1'b1;
        // The edge that writes bit 0 is the last conversion edge.
        if (last_bit) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: input latch, bit index and serial result
  // ---------------------------------------------------------------------------
  // bin is only written in CONV, so it holds through DONE and keeps its last
  // value in IDLE until the next accept clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q   <= '0;
      bin      <= '0;
      idx      <= IDX_MSB;
      prev_bit <= 1'b0;
    end else if (accept) begin
      gray_q   <= gray;
      bin      <= '0;
      idx      <= IDX_MSB;
      prev_bit <= 1'b0;
    end else if (busy) begin
      bin[idx] <= new_bit;
      prev_bit <= new_bit;
      // Index stops at 0; the state change to DONE takes over from here.
      if (!last_bit) begin
        idx <= idx - IDX_W'(1);
      end
    end
  end

endmodule
